// File: rtl/logic_gate_tester_pkg.sv
// Shared types and constants for the logic gate tester.
package logic_gate_tester_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Truth tables for the tutorial gate set; bit index = {A,B}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Expected gate output for input vector {A,B}.
    function automatic logic expected_out(input logic [3:0] tt, input logic [1:0] vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/logic_gate_tester_if.sv
// Control, gate and status signals between the test controller and the tester.
interface logic_gate_tester_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             gate_o;
    logic             gate_a;
    logic             gate_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       fail_mask;
    logic [CNT_W-1:0] err_count;

    // Controller side; also supplies the gate output back to the tester.
    modport master (
        output start, abort, gate_o,
        input  gate_a, gate_b, busy, done, pass, fail_mask, err_count
    );

    // Tester side.
    modport slave (
        input  start, abort, gate_o,
        output gate_a, gate_b, busy, done, pass, fail_mask, err_count
    );
endinterface

// File: rtl/logic_gate_tester_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);
    logic [Width-1:0] count_q, count_d;

    // Next count: clear, or increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/logic_gate_tester.sv
// Sweeps a 2-input gate through all input vectors, checks it against a truth table
// and reports a failure mask, saturating error count and pass/done status.
module logic_gate_tester
    import logic_gate_tester_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE   = TT_NAND,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PASSES        = 2,
    parameter int unsigned CNT_W         = 8
) (
    input logic               clk,
    input logic               reset,
    logic_gate_tester_if.slave bus
);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PassLast   = PW'(PASSES - 1);

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       mask_q, mask_d;
    logic             err_clr, err_inc;
    logic [CNT_W-1:0] err_count;

    logic sample_en;
    logic last_sample;
    logic mismatch;

    // Sample on the final cycle of each vector hold unless the run is being aborted.
    assign sample_en   = (state_q == StSettle) && !bus.abort && (settle_q == SettleLast);
    assign last_sample = sample_en && (vec_q == 2'b11) && (pcnt_q == PassLast);
    assign mismatch    = (bus.gate_o != expected_out(TRUTH_TABLE, vec_q));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.start) state_d = StSettle;
            StSettle: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (last_sample) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the vector/settle/pass counters and the registered outputs.
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        pcnt_d   = pcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        mask_d   = mask_q;
        err_clr  = 1'b0;
        err_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    busy_d   = 1'b1;
                    vec_d    = 2'b00;
                    settle_d = '0;
                    pcnt_d   = '0;
                    mask_d   = 4'b0000;
                    err_clr  = 1'b1;
                    pass_d   = 1'b0;
                end
            end
            StSettle: begin
                if (bus.abort) begin
                    // Partial mask and count are kept for inspection.
                    busy_d   = 1'b0;
                    vec_d    = 2'b00;
                    settle_d = '0;
                    pcnt_d   = '0;
                    pass_d   = 1'b0;
                end else if (sample_en) begin
                    if (mismatch) begin
                        mask_d[vec_q] = 1'b1;
                        err_inc       = 1'b1;
                    end
                    settle_d = '0;
                    vec_d    = vec_q + 2'd1;
                    if (vec_q == 2'b11) begin
                        pcnt_d = (pcnt_q == PassLast) ? '0 : pcnt_q + PW'(1);
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StDone: begin
                // err_count already includes the final sample here.
                done_d = 1'b1;
                busy_d = 1'b0;
                vec_d  = 2'b00;
                pass_d = (err_count == '0);
            end
            default: begin
                busy_d = 1'b0;
                vec_d  = 2'b00;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q    <= 2'b00;
            settle_q <= '0;
            pcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mask_q   <= 4'b0000;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            pcnt_q   <= pcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            mask_q   <= mask_d;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (err_clr),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

    assign bus.gate_a    = vec_q[1];
    assign bus.gate_b    = vec_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_logic_gate_tester.sv
// Bench for logic_gate_tester: two instances (default and small saturating counter),
// each driving a modelled gate whose truth table is chosen per run.
module tb_logic_gate_tester;
    import logic_gate_tester_pkg::*;

    localparam int unsigned S  = 4;
    localparam int unsigned PA = 2;
    localparam int unsigned PS = 3;
    localparam int unsigned WS = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic_gate_tester_if #(.CNT_W(8))  if_a ();
    logic_gate_tester_if #(.CNT_W(WS)) if_s ();

    logic [3:0] gtt_a, gtt_s;
    assign if_a.gate_o = gtt_a[{if_a.gate_a, if_a.gate_b}];
    assign if_s.gate_o = gtt_s[{if_s.gate_a, if_s.gate_b}];

    logic_gate_tester #(
        .TRUTH_TABLE   (TT_NAND),
        .SETTLE_CYCLES (S),
        .PASSES        (PA),
        .CNT_W         (8)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    logic_gate_tester #(
        .TRUTH_TABLE   (TT_NAND),
        .SETTLE_CYCLES (S),
        .PASSES        (PS),
        .CNT_W         (WS)
    ) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s)
    );

    bit         sel = 1'b0;
    logic       cur_busy, cur_done, cur_pass;
    logic [1:0] cur_vec;
    logic [3:0] cur_mask;
    logic [7:0] cur_err;
    assign cur_busy = sel ? if_s.busy : if_a.busy;
    assign cur_done = sel ? if_s.done : if_a.done;
    assign cur_pass = sel ? if_s.pass : if_a.pass;
    assign cur_vec  = sel ? {if_s.gate_a, if_s.gate_b} : {if_a.gate_a, if_a.gate_b};
    assign cur_mask = sel ? if_s.fail_mask : if_a.fail_mask;
    assign cur_err  = sel ? {6'd0, if_s.err_count} : if_a.err_count;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) if_s.start = v; else if_a.start = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) if_s.abort = v; else if_a.abort = v;
    endtask

    // Reference: total mismatches over all passes, clamped to the counter maximum.
    function automatic int unsigned ref_errs(input logic [3:0] mism, input int unsigned passes,
                                             input int unsigned w);
        int unsigned e  = passes * $countones(mism);
        int unsigned mx = (1 << w) - 1;
        return (e > mx) ? mx : e;
    endfunction

    // One complete run; optionally re-pulse start mid-run and in the DONE cycle.
    task automatic run(input string tag, input bit s, input logic [3:0] gtt, input bit repulse);
        int unsigned p, w, total, exp_err;
        logic [3:0]  mism;
        logic [1:0]  ev;
        int          seq_err, done_at, done_cnt;
        sel = s;
        p   = s ? PS : PA;
        w   = s ? WS : 8;
        if (s) gtt_s = gtt; else gtt_a = gtt;
        mism    = gtt ^ TT_NAND;
        exp_err = ref_errs(mism, p, w);
        total   = 4 * p * S;
        seq_err = 0;
        done_at = -1;
        done_cnt = 0;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int n = 0; n < int'(total) + 8; n++) begin
            ev = 2'((n / S) % 4);
            if (n < int'(total) && cur_vec !== ev) seq_err++;
            if (n == 0) check({tag, ".busy_run"}, 32'(cur_busy), 32'd1);
            if (cur_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    check({tag, ".mask"}, 32'(cur_mask), 32'(mism));
                    check({tag, ".err"},  32'(cur_err),  32'(exp_err));
                    check({tag, ".pass"}, 32'(cur_pass), 32'(exp_err == 0));
                    check({tag, ".busy_done"}, 32'(cur_busy), 32'd0);
                end
            end
            set_start(repulse && (n == 5 || n == int'(total)));
            @(negedge clk);
        end
        check({tag, ".vec_seq"},  32'(seq_err),  32'd0);
        check({tag, ".latency"},  32'(done_at),  32'(total + 1));
        check({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, ".idle_after"}, 32'(cur_busy), 32'd0);
    endtask

    initial begin
        int          abort_n, samples, done_cnt;
        logic [3:0]  mism, exp_mask;
        reset      = 1'b1;
        if_a.start = 1'b0;
        if_a.abort = 1'b0;
        if_s.start = 1'b0;
        if_s.abort = 1'b0;
        gtt_a      = TT_NAND;
        gtt_s      = TT_NAND;
        #12;
        check("rst.busy", 32'(if_a.busy), 32'd0);
        check("rst.done", 32'(if_a.done), 32'd0);
        check("rst.pass", 32'(if_a.pass), 32'd0);
        check("rst.vec",  32'({if_a.gate_a, if_a.gate_b}), 32'd0);
        check("rst.mask", 32'(if_a.fail_mask), 32'd0);
        check("rst.err",  32'(if_a.err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run("nand", 1'b0, TT_NAND, 1'b0);
        run("and_on_nand", 1'b0, TT_AND, 1'b0);
        run("tied1_sat", 1'b1, 4'b1111, 1'b0);
        run("repulse", 1'b0, TT_NAND, 1'b1);

        // Abort 10 cycles after the start edge with an always-wrong gate.
        sel     = 1'b0;
        gtt_a   = TT_AND;
        mism    = TT_AND ^ TT_NAND;
        abort_n = 10;
        samples = abort_n / S;
        exp_mask = 4'b0000;
        for (int v = 0; v < samples && v < 4; v++) exp_mask[v] = mism[v];
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int n = 0; n < abort_n - 1; n++) @(negedge clk);
        set_abort(1'b1);
        @(negedge clk);
        set_abort(1'b0);
        check("abort.busy", 32'(cur_busy), 32'd0);
        check("abort.vec",  32'(cur_vec),  32'd0);
        check("abort.pass", 32'(cur_pass), 32'd0);
        check("abort.mask", 32'(cur_mask), 32'(exp_mask));
        check("abort.err",  32'(cur_err),  32'(samples));
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (cur_done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort.no_done", 32'(done_cnt), 32'd0);
        run("after_abort", 1'b0, TT_NAND, 1'b0);

        // Randomly chosen attached gates.
        for (int i = 0; i < 4; i++) run("rnd_a", 1'b0, 4'($urandom), 1'b0);
        for (int i = 0; i < 2; i++) run("rnd_s", 1'b1, 4'($urandom), 1'b0);

        // Asynchronous reset between edges mid-run.
        sel   = 1'b0;
        gtt_a = TT_AND;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int n = 0; n < 12; n++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst.busy", 32'(if_a.busy), 32'd0);
        check("arst.done", 32'(if_a.done), 32'd0);
        check("arst.pass", 32'(if_a.pass), 32'd0);
        check("arst.vec",  32'({if_a.gate_a, if_a.gate_b}), 32'd0);
        check("arst.mask", 32'(if_a.fail_mask), 32'd0);
        check("arst.err",  32'(if_a.err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (if_a.done === 1'b1 || if_a.busy === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("arst.quiet", 32'(done_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_gate_tester.md
Name: logic_gate_tester

Overview:
Self-checking sequencer for a 2-input combinational logic gate under test.
- On a start request it drives the gate's A/B inputs through all four vectors (00,01,10,11), once per pass.
- After a programmable settle time it samples the gate output and compares it with a parameterised truth table.
- It accumulates a per-vector failure mask and a saturating error count, then reports pass/fail with a busy/done handshake.
- It sits between a board-level test controller (buttons, UART command) and any gate module from the tutorial gate set (NAND, NOR, XOR, ...).

Parameters:
- TRUTH_TABLE, 4'b0111, expected output; bit index = {A,B}; default is NAND.
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling; must be >= 1.
- PASSES, 2, number of full 4-vector sweeps per run; must be >= 1.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  cancels a run in progress.
- gate_o  input  1  output of the gate under test.
- gate_a  output  1  A input to the gate under test.
- gate_b  output  1  B input to the gate under test.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes normally.
- pass  output  1  high when the last completed run had zero mismatches; held until the next start or abort.
- fail_mask  output  4  bit i set if vector i ({A,B}=i) mismatched in any pass.
- err_count  output  CNT_W  total mismatches across all passes; saturates at all-ones.

Behaviour:
- Reset (async, active-high): state=IDLE; gate_a=gate_b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0; internal vector, settle and pass counters=0.
- States: IDLE, SETTLE, DONE.
- IDLE, start=1 at edge e0:
  - next state SETTLE.
  - busy=1; {gate_a,gate_b}=2'b00; settle_cnt=0; pass_cnt=0.
  - fail_mask=0, err_count=0, pass=0.
- SETTLE, each cycle:
  - settle_cnt increments.
  - On the edge where settle_cnt==SETTLE_CYCLES-1, gate_o is sampled and compared with TRUTH_TABLE[{gate_a,gate_b}].
  - On mismatch: set fail_mask bit; err_count+1, saturating.
  - Then settle_cnt=0 and the vector advances.
- Vector order: 00->01->10->11.
  - After 11, pass_cnt increments and the vector wraps to 00.
  - After 11 on pass PASSES-1, go to DONE.
- Each vector is held for exactly SETTLE_CYCLES cycles; the vector changes on the same edge as the sample.
- DONE (one cycle):
  - done=1, busy=0, {gate_a,gate_b}=00.
  - pass=(err_count==0), using the final count including the last sample.
  - Next state IDLE.
- Latency: start edge to done-high cycle = 4*PASSES*SETTLE_CYCLES + 1 cycles.
- start while busy or in DONE: ignored, no queuing.
- abort=1 in SETTLE:
  - next edge to IDLE; busy=0, gate_a=gate_b=0, pass=0; done not pulsed.
  - fail_mask and err_count keep their partial values.
- abort in IDLE/DONE: no effect, except DONE still pulses done.
- abort and start together in IDLE: start wins.
- Saturation: err_count holds at 2^CNT_W-1 once reached; fail_mask unaffected.
- Reset mid-run: immediate return to reset values; no done pulse.
- Outputs are registered; gate_a/gate_b have no combinational path from inputs.

Decomposition:
- Shared package/include:
  - state encoding localparams (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2).
  - Truth-table constants: TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One natural sub-module, sat_counter (parameterised width, inc/clear, saturating), used for err_count.
- The settle and pass counters stay inline.

Test Plan:
- NAND gate attached, defaults, pulse start: gate_a/b steps 00,01,10,11 every 4 cycles, twice; done pulses 33 cycles after the start edge; pass=1, fail_mask=0, err_count=0.
- Tester TRUTH_TABLE=TT_NAND but AND gate attached, PASSES=2: every vector mismatches; fail_mask=4'b1111, err_count=8, pass=0.
- gate_o tied 1 with NAND table, PASSES=3, CNT_W=2: only vector 11 fails; fail_mask=4'b1000; err_count=3, saturated at 2'b11; pass=0.
- abort asserted 10 cycles into a run: busy drops next edge, gate_a/b=00, no done pulse, pass=0; a new start then completes normally with pass=1.
- start re-pulsed mid-run and in the DONE cycle: no restart; done pulses exactly once at cycle 33.
- reset asserted asynchronously mid-SETTLE (between edges): all outputs zero immediately; no done pulse follows.
